nnet_vector_framer: RTL and testbench

Transmit-side framer for the NN streaming path. It takes the raw sample stream from user/HLS code and cuts it into packets of `pkt_size` samples, asserting `tlast` on the final beat. It generates the 128-bit CHDR header on `o_tuser` with its own sequence number, source SID and destination SID. It sits between the user core output and the axi_wrapper input, for blocks whose core emits vectors with no header context.

---
 rtl/nnet_framer_pkg.sv | 26 ++
 rtl/nnet_framer_out_reg.sv | 54 +++++
 rtl/nnet_vector_framer.sv | 146 ++++++++++++++
 tb/tb_nnet_vector_framer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/nnet_framer_pkg.sv
// Shared constants for the NN vector framer: CHDR header field offsets,
// packet type encoding, sequence number width and the payload length helper.
package nnet_framer_pkg;

    localparam int SEQNUM_W = 12;

    localparam logic [1:0] PKT_TYPE_DATA = 2'b00;

    localparam int HDR_TYPE_LSB     = 126;
    localparam int HDR_HAS_TIME_BIT = 125;
    localparam int HDR_EOB_BIT      = 124;
    localparam int HDR_SEQ_LSB      = 112;
    localparam int HDR_LEN_LSB      = 96;
    localparam int HDR_SRC_LSB      = 80;
    localparam int HDR_DST_LSB      = 64;
    localparam int HDR_TS_LSB       = 0;

    // Nominal payload length in bytes for a packet of 'samples' beats of
    // 2*width bits each, truncated to the 16-bit header length field.
    function automatic logic [15:0] pkt_len_bytes(input logic [15:0] samples, input int width);
        logic [31:0] bytes;
        bytes = 32'(samples) * 32'((2 * width) / 8);
        return bytes[15:0];
    endfunction

endpackage

// File: rtl/nnet_framer_out_reg.sv
// Single-stage data+last+user register slice with valid/ready handshake;
// upstream ready is combinational so back-to-back beats flow without bubbles.
module nnet_framer_out_reg #(
    parameter int DATA_W = 32,
    parameter int USER_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    input  logic [USER_W-1:0] in_user_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic [USER_W-1:0] out_user_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic [USER_W-1:0] user_q;
    logic              valid_q;
    logic              load;

    assign in_ready_o = ~valid_q | out_ready_i;
    assign load       = in_valid_i & in_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the slice behaves the same in any tool.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= in_data_i;
            last_q  <= in_last_i;
            user_q  <= in_user_i;
            valid_q <= 1'b1;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign out_user_o  = user_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/nnet_vector_framer.sv
// Cuts a headerless sample stream into pkt_size-beat packets with a CHDR header
// on o_tuser. Define NNET_FRAMER_TIMESTAMP_EN to carry a beat-count timestamp.
module nnet_vector_framer
    import nnet_framer_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int HEADER_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [15:0]             src_sid,
    input  logic [15:0]             next_dst_sid,
    input  logic [15:0]             pkt_size,
    input  logic [2*WIDTH-1:0]      s_axis_data_tdata,
    input  logic                    s_axis_data_tlast,
    input  logic                    s_axis_data_tvalid,
    output logic                    s_axis_data_tready,
    output logic [2*WIDTH-1:0]      o_tdata,
    output logic                    o_tlast,
    output logic                    o_tvalid,
    input  logic                    o_tready,
    output logic [HEADER_WIDTH-1:0] o_tuser,
    output logic [SEQNUM_W-1:0]     seqnum
);

    localparam int DATA_W = 2 * WIDTH;

    logic                    accept;
    logic                    sof;
    logic                    is_last;
    logic [15:0]             eff_size;
    logic [15:0]             cur_size;
    logic [15:0]             cnt_q, cnt_d;
    logic [15:0]             size_q, size_d;
    logic [SEQNUM_W-1:0]     seqnum_q, seqnum_d;
    logic [HEADER_WIDTH-1:0] hdr_q, hdr_d;
    logic [HEADER_WIDTH-1:0] hdr_new;
    logic [HEADER_WIDTH-1:0] hdr_cur;
    logic                    has_time;
    logic [63:0]             ts_cur;

    assign accept   = s_axis_data_tvalid & s_axis_data_tready;
    assign sof      = (cnt_q == 16'd0);
    assign eff_size = (pkt_size == 16'd0) ? 16'd1 : pkt_size;
    assign cur_size = sof ? eff_size : size_q;
    assign is_last  = (cnt_q == cur_size - 16'd1) | s_axis_data_tlast;

`ifdef NNET_FRAMER_TIMESTAMP_EN
    logic [63:0] ts_q, ts_d;

    // Advances by the beats actually sent, so short packets count correctly.
    always_comb begin
        ts_d = ts_q;
        if (accept && is_last) begin
            ts_d = ts_q + 64'(cnt_q) + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign has_time = 1'b1;
    assign ts_cur   = ts_q;
`else
    assign has_time = 1'b0;
    assign ts_cur   = '0;
`endif

    always_comb begin
        hdr_new = '0;
        hdr_new[HDR_TYPE_LSB +: 2]         = PKT_TYPE_DATA;
        hdr_new[HDR_HAS_TIME_BIT]          = has_time;
        hdr_new[HDR_EOB_BIT]               = 1'b0;
        hdr_new[HDR_SEQ_LSB +: SEQNUM_W]   = seqnum_q;
        hdr_new[HDR_LEN_LSB +: 16]         = pkt_len_bytes(eff_size, WIDTH);
        hdr_new[HDR_SRC_LSB +: 16]         = src_sid;
        hdr_new[HDR_DST_LSB +: 16]         = next_dst_sid;
        hdr_new[HDR_TS_LSB +: 64]          = ts_cur;
    end

    // The first beat uses the freshly built header; later beats reuse the latch.
    assign hdr_cur = sof ? hdr_new : hdr_q;

    // NOTE: every signal gets a default before the branches, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        cnt_d    = cnt_q;
        size_d   = size_q;
        seqnum_d = seqnum_q;
        hdr_d    = hdr_q;
        if (accept) begin
            if (sof) begin
                size_d = eff_size;
                hdr_d  = hdr_new;
            end
            if (is_last) begin
                cnt_d    = 16'd0;
                seqnum_d = seqnum_q + 12'd1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q    <= '0;
            size_q   <= '0;
            seqnum_q <= '0;
            hdr_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            size_q   <= size_d;
            seqnum_q <= seqnum_d;
            hdr_q    <= hdr_d;
        end
    end

    assign seqnum = seqnum_q;

    nnet_framer_out_reg #(
        .DATA_W (DATA_W),
        .USER_W (HEADER_WIDTH)
    ) u_out_reg (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_data_i   (s_axis_data_tdata),
        .in_last_i   (is_last),
        .in_user_i   (hdr_cur),
        .in_valid_i  (s_axis_data_tvalid),
        .in_ready_o  (s_axis_data_tready),
        .out_data_o  (o_tdata),
        .out_last_o  (o_tlast),
        .out_user_o  (o_tuser),
        .out_valid_o (o_tvalid),
        .out_ready_i (o_tready)
    );

endmodule

// File: tb/tb_nnet_vector_framer.sv
// Directed self-checking bench for nnet_vector_framer; expected headers are
// assembled independently from hand-computed sequence, length and time values.
module tb_nnet_vector_framer;

`ifdef NNET_FRAMER_TIMESTAMP_EN
    localparam bit HAS_TIME = 1'b1;
`else
    localparam bit HAS_TIME = 1'b0;
`endif

    localparam logic [15:0] SRC = 16'h1234;
    localparam logic [15:0] DST = 16'hABCD;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic [15:0]  src_sid;
    logic [15:0]  next_dst_sid;
    logic [15:0]  pkt_size;
    logic [31:0]  s_data;
    logic         s_last;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  o_tdata;
    logic         o_tlast;
    logic         o_tvalid;
    logic         o_tready;
    logic [127:0] o_tuser;
    logic [11:0]  seqnum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nnet_vector_framer #(
        .WIDTH        (16),
        .HEADER_WIDTH (128)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .clear              (clear),
        .src_sid            (src_sid),
        .next_dst_sid       (next_dst_sid),
        .pkt_size           (pkt_size),
        .s_axis_data_tdata  (s_data),
        .s_axis_data_tlast  (s_last),
        .s_axis_data_tvalid (s_valid),
        .s_axis_data_tready (s_ready),
        .o_tdata            (o_tdata),
        .o_tlast            (o_tlast),
        .o_tvalid           (o_tvalid),
        .o_tready           (o_tready),
        .o_tuser            (o_tuser),
        .seqnum             (seqnum)
    );

    function automatic logic [127:0] exp_hdr(input int seq, input int size, input logic [63:0] ts);
        logic [11:0] s;
        logic [15:0] len;
        logic [63:0] t;
        s   = seq[11:0];
        len = 16'(size * 4);
        t   = HAS_TIME ? ts : 64'd0;
        return {2'b00, HAS_TIME, 1'b0, s, len, SRC, DST, t};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat with o_tready high; it is accepted at the next edge.
    task automatic send(input int data, input bit last);
        s_valid = 1'b1;
        s_data  = 32'(data);
        s_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input int data, input bit last,
                               input int seq, input int size, input logic [63:0] ts);
        check({tag, ".valid"}, 128'(o_tvalid), 128'(1));
        check({tag, ".data"},  128'(o_tdata),  128'(data));
        check({tag, ".last"},  128'(o_tlast),  128'(last));
        check({tag, ".user"},  o_tuser,        exp_hdr(seq, size, ts));
    endtask

    initial begin
        int sent;
        int got;

        reset        = 1'b1;
        clear        = 1'b0;
        src_sid      = SRC;
        next_dst_sid = DST;
        pkt_size     = 16'd4;
        s_data       = '0;
        s_last       = 1'b0;
        s_valid      = 1'b0;
        o_tready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid",  128'(o_tvalid), 128'(0));
        check("rst.last",   128'(o_tlast),  128'(0));
        check("rst.data",   128'(o_tdata),  128'(0));
        check("rst.user",   o_tuser,        128'(0));
        check("rst.seqnum", 128'(seqnum),   128'(0));
        check("rst.ready",  128'(s_ready),  128'(1));
        reset = 1'b0;

        // Two 4-beat packets, continuous, sink always ready.
        for (int i = 0; i < 8; i++) begin
            send(i, 1'b0);
            expect_beat("cont", i, (i % 4) == 3, i / 4, 4, 64'(4 * (i / 4)));
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        check("cont.idle_valid", 128'(o_tvalid), 128'(0));
        check("cont.seqnum",     128'(seqnum),   128'(2));

        // Same stimulus with the sink toggling ready 1,0,1,0...
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            o_tready = (cyc % 2) == 0;
            s_valid  = (sent < 8);
            s_data   = 32'(sent);
            s_last   = 1'b0;
            #1;
            if (o_tvalid) begin
                check("stall.data", 128'(o_tdata), 128'(got));
                check("stall.last", 128'(o_tlast), 128'((got % 4) == 3));
                check("stall.user", o_tuser, exp_hdr(2 + got / 4, 4, 64'(8 + 4 * (got / 4))));
                if (o_tready) got++;
            end
            if (s_valid && s_ready) sent++;
            @(posedge clk);
            #1;
        end
        s_valid  = 1'b0;
        o_tready = 1'b1;
        check("stall.count",  128'(got),    128'(8));
        check("stall.seqnum", 128'(seqnum), 128'(4));

        // Early end of vector: 3-beat packet, then the next packet restarts.
        pkt_size = 16'd8;
        send(100, 1'b0);
        expect_beat("tlast.b0", 100, 1'b0, 4, 8, 64'd16);
        send(101, 1'b0);
        expect_beat("tlast.b1", 101, 1'b0, 4, 8, 64'd16);
        send(102, 1'b1);
        expect_beat("tlast.b2", 102, 1'b1, 4, 8, 64'd16);
        send(103, 1'b0);
        expect_beat("tlast.next0", 103, 1'b0, 5, 8, 64'd19);
        send(104, 1'b1);
        expect_beat("tlast.next1", 104, 1'b1, 5, 8, 64'd19);

        // pkt_size changes mid-packet; takes effect on the following packet.
        pkt_size = 16'd4;
        send(200, 1'b0);
        expect_beat("resize.a0", 200, 1'b0, 6, 4, 64'd21);
        pkt_size = 16'd6;
        for (int b = 1; b < 4; b++) begin
            send(200 + b, 1'b0);
            expect_beat("resize.a", 200 + b, b == 3, 6, 4, 64'd21);
        end
        for (int b = 0; b < 6; b++) begin
            send(204 + b, 1'b0);
            expect_beat("resize.b", 204 + b, b == 5, 7, 6, 64'd25);
        end

        // Reset after 2 of 4 beats abandons the packet.
        pkt_size = 16'd4;
        send(300, 1'b0);
        expect_beat("mid.b0", 300, 1'b0, 8, 4, 64'd31);
        send(301, 1'b0);
        s_valid = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid.valid",  128'(o_tvalid), 128'(0));
        check("mid.last",   128'(o_tlast),  128'(0));
        check("mid.data",   128'(o_tdata),  128'(0));
        check("mid.user",   o_tuser,        128'(0));
        check("mid.seqnum", 128'(seqnum),   128'(0));
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                send(400 + 4 * p + b, 1'b0);
                expect_beat("post_rst", 400 + 4 * p + b, b == 3, p, 4, 64'(4 * p));
            end
        end
        check("post_rst.seqnum", 128'(seqnum), 128'(3));

        // Soft clear, then 4097 single-beat packets; pkt_size 0 acts as 1.
        s_valid = 1'b0;
        clear   = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr.seqnum", 128'(seqnum),   128'(0));
        check("clr.valid",  128'(o_tvalid), 128'(0));
        for (int k = 0; k < 4097; k++) begin
            pkt_size = (k % 2 == 1) ? 16'd1 : 16'd0;
            send(k, 1'b0);
            check("wrap.last", 128'(o_tlast), 128'(1));
            check("wrap.user", o_tuser, exp_hdr(k % 4096, 1, 64'(k)));
        end
        s_valid = 1'b0;
        check("wrap.seqnum", 128'(seqnum), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
